// File: rtl/muldiv_arbiter_if.sv
// Signal bundle between the two execute sub-units, the shared muldiv unit and the arbiter.
// The arbiter takes the slave view; whoever drives requests and the unit takes the master view.
interface muldiv_arbiter_if #(
    parameter int DATA_W = 32
);
    logic                  req1_i;
    logic [1:0]            op1_i;
    logic [DATA_W-1:0]     opa1_i;
    logic [DATA_W-1:0]     opb1_i;
    logic                  req2_i;
    logic [1:0]            op2_i;
    logic [DATA_W-1:0]     opa2_i;
    logic [DATA_W-1:0]     opb2_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  unit_ready_i;
    logic [2*DATA_W-1:0]   unit_res_i;
    logic                  unit_start_o;
    logic [1:0]            unit_op_o;
    logic [DATA_W-1:0]     unit_a_o;
    logic [DATA_W-1:0]     unit_b_o;
    logic                  unit_annul_o;
    logic                  stall1_o;
    logic                  stall2_o;
    logic                  done1_o;
    logic                  done2_o;
    logic [2*DATA_W-1:0]   result_o;

    modport slave (
        input  req1_i, op1_i, opa1_i, opb1_i,
        input  req2_i, op2_i, opa2_i, opb2_i,
        input  stall_i, flush_i, unit_ready_i, unit_res_i,
        output unit_start_o, unit_op_o, unit_a_o, unit_b_o, unit_annul_o,
        output stall1_o, stall2_o, done1_o, done2_o, result_o
    );

    modport master (
        output req1_i, op1_i, opa1_i, opb1_i,
        output req2_i, op2_i, opa2_i, opb2_i,
        output stall_i, flush_i, unit_ready_i, unit_res_i,
        input  unit_start_o, unit_op_o, unit_a_o, unit_b_o, unit_annul_o,
        input  stall1_o, stall2_o, done1_o, done2_o, result_o
    );
endinterface

// File: rtl/muldiv_arbiter.sv
// Shares one multi-cycle MULT/MULTU/DIV/DIVU unit between ex_sub1 (older) and ex_sub2 (younger):
// arbitrates, latches operands, sequences start/annul and hands the {hi,lo} result back.
module muldiv_arbiter #(
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 0
) (
    input  logic            clk,
    input  logic            rst,
    muldiv_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                owner_q;    // 0: sub1, 1: sub2
    logic                last_q;     // sub served most recently, same encoding
    logic                start_q;
    logic                annul_q;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] result_q;
    logic                grant_valid;
    logic                grant_sel;
    logic                done1;
    logic                done2;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = bus.req1_i | bus.req2_i;
        grant_sel   = bus.req2_i;
        if (bus.req1_i && bus.req2_i) begin
            grant_sel = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (grant_valid)      state_d = S_RUN;
                S_RUN:   if (bus.unit_ready_i) state_d = S_DONE;
                S_DONE:  if (!bus.stall_i)     state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A flush in RUN suppresses both the grant path and a same-cycle unit result.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            start_q  <= 1'b0;
            annul_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            start_q <= 1'b0;
            annul_q <= bus.flush_i && (state_q == S_RUN);
            if (!bus.flush_i) begin
                if (state_q == S_IDLE && grant_valid) begin
                    owner_q <= grant_sel;
                    start_q <= 1'b1;
                    op_q    <= grant_sel ? bus.op2_i  : bus.op1_i;
                    a_q     <= grant_sel ? bus.opa2_i : bus.opa1_i;
                    b_q     <= grant_sel ? bus.opb2_i : bus.opb1_i;
                end
                if (state_q == S_RUN && bus.unit_ready_i) begin
                    result_q <= bus.unit_res_i;
                    last_q   <= owner_q;
                end
            end
        end
    end

    always_comb begin
        done1 = 1'b0;
        done2 = 1'b0;
        if (state_q == S_DONE && !bus.flush_i) begin
            done1 = ~owner_q;
            done2 = owner_q;
        end
    end

    assign bus.unit_start_o = start_q;
    assign bus.unit_op_o    = op_q;
    assign bus.unit_a_o     = a_q;
    assign bus.unit_b_o     = b_q;
    assign bus.unit_annul_o = annul_q;
    assign bus.done1_o      = done1;
    assign bus.done2_o      = done2;
    assign bus.stall1_o     = bus.req1_i & ~done1;
    assign bus.stall2_o     = bus.req2_i & ~done2;
    assign bus.result_o     = result_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: a fixed-priority and a round-robin instance, each compared every cycle
// against a transaction-level model, plus hand-computed expectations for the directed scenarios.
module tb_muldiv_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic          req1;
        logic [1:0]    op1;
        logic [DW-1:0] a1;
        logic [DW-1:0] b1;
        logic          req2;
        logic [1:0]    op2;
        logic [DW-1:0] a2;
        logic [DW-1:0] b2;
        logic          stall;
        logic          flush;
        logic          ready;
        logic [2*DW-1:0] res;
    } in_t;

    typedef struct packed {
        logic          start;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          annul;
        logic          stall1;
        logic          stall2;
        logic          done1;
        logic          done2;
        logic [2*DW-1:0] result;
    } out_t;

    typedef struct packed {
        logic          pending;   // op handed to the unit, result not back yet
        logic          fresh;     // first cycle of the op
        logic          holding;   // result being offered to its owner
        logic          who;       // 0: sub1, 1: sub2
        logic          prev;      // sub served most recently
        logic          annul;
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2*DW-1:0] result;
    } model_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    in_t    drv [2];
    model_t ms  [2];
    out_t   dut0;
    out_t   dut1;
    int     n_cmp = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    muldiv_arbiter_if #(.DATA_W(DW)) bus0 ();
    muldiv_arbiter_if #(.DATA_W(DW)) bus1 ();

    assign bus0.req1_i = drv[0].req1;   assign bus1.req1_i = drv[1].req1;
    assign bus0.op1_i  = drv[0].op1;    assign bus1.op1_i  = drv[1].op1;
    assign bus0.opa1_i = drv[0].a1;     assign bus1.opa1_i = drv[1].a1;
    assign bus0.opb1_i = drv[0].b1;     assign bus1.opb1_i = drv[1].b1;
    assign bus0.req2_i = drv[0].req2;   assign bus1.req2_i = drv[1].req2;
    assign bus0.op2_i  = drv[0].op2;    assign bus1.op2_i  = drv[1].op2;
    assign bus0.opa2_i = drv[0].a2;     assign bus1.opa2_i = drv[1].a2;
    assign bus0.opb2_i = drv[0].b2;     assign bus1.opb2_i = drv[1].b2;
    assign bus0.stall_i = drv[0].stall; assign bus1.stall_i = drv[1].stall;
    assign bus0.flush_i = drv[0].flush; assign bus1.flush_i = drv[1].flush;
    assign bus0.unit_ready_i = drv[0].ready; assign bus1.unit_ready_i = drv[1].ready;
    assign bus0.unit_res_i   = drv[0].res;   assign bus1.unit_res_i   = drv[1].res;

    assign dut0 = '{start: bus0.unit_start_o, op: bus0.unit_op_o, a: bus0.unit_a_o, b: bus0.unit_b_o,
                    annul: bus0.unit_annul_o, stall1: bus0.stall1_o, stall2: bus0.stall2_o,
                    done1: bus0.done1_o, done2: bus0.done2_o, result: bus0.result_o};
    assign dut1 = '{start: bus1.unit_start_o, op: bus1.unit_op_o, a: bus1.unit_a_o, b: bus1.unit_b_o,
                    annul: bus1.unit_annul_o, stall1: bus1.stall1_o, stall2: bus1.stall2_o,
                    done1: bus1.done1_o, done2: bus1.done2_o, result: bus1.result_o};

    muldiv_arbiter #(.DATA_W(DW), .ROUND_ROBIN(0)) u_dut_fixed (.clk(clk), .rst(rst), .bus(bus0));
    muldiv_arbiter #(.DATA_W(DW), .ROUND_ROBIN(1)) u_dut_rr    (.clk(clk), .rst(rst), .bus(bus1));

    // Reference unit arithmetic: hi = remainder / upper product, lo = quotient / lower product.
    function automatic logic [2*DW-1:0] unit_calc(input logic [1:0] op, input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b);
        logic signed [2*DW-1:0] sa;
        logic signed [2*DW-1:0] sb;
        logic signed [DW-1:0]   q;
        logic signed [DW-1:0]   r;
        logic [2*DW-1:0]        res;
        sa = {{DW{a[DW-1]}}, a};
        sb = {{DW{b[DW-1]}}, b};
        res = '0;
        if (op[1] && b == '0) begin
            res = {a, {DW{1'b1}}};
        end else begin
            case (op)
                2'b00: res = sa * sb;
                2'b01: res = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                2'b10: begin
                    q   = $signed(a) / $signed(b);
                    r   = $signed(a) % $signed(b);
                    res = {r, q};
                end
                default: res = {a % b, a / b};
            endcase
        end
        return res;
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s      = '0;
        s.prev = 1'b1;
        return s;
    endfunction

    function automatic model_t model_next(input model_t s, input in_t i, input bit rr);
        model_t n;
        n       = s;
        n.fresh = 1'b0;
        n.annul = i.flush && s.pending;
        if (i.flush) begin
            n.pending = 1'b0;
            n.holding = 1'b0;
        end else if (s.pending) begin
            if (i.ready) begin
                n.pending = 1'b0;
                n.holding = 1'b1;
                n.result  = i.res;
                n.prev    = s.who;
            end
        end else if (s.holding) begin
            n.holding = i.stall;
        end else if (i.req1 || i.req2) begin
            if (i.req1 && i.req2) n.who = rr ? !s.prev : 1'b0;
            else                  n.who = i.req2;
            n.op      = n.who ? i.op2 : i.op1;
            n.a       = n.who ? i.a2  : i.a1;
            n.b       = n.who ? i.b2  : i.b1;
            n.pending = 1'b1;
            n.fresh   = 1'b1;
        end
        return n;
    endfunction

    function automatic out_t model_out(input model_t s, input in_t i);
        out_t o;
        o.start  = s.fresh;
        o.op     = s.op;
        o.a      = s.a;
        o.b      = s.b;
        o.annul  = s.annul;
        o.done1  = s.holding && !s.who && !i.flush;
        o.done2  = s.holding &&  s.who && !i.flush;
        o.stall1 = i.req1 && !o.done1;
        o.stall2 = i.req2 && !o.done2;
        o.result = s.result;
        return o;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ms[k] <= rst ? model_reset() : model_next(ms[k], drv[k], k == 1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        out_t got;
        out_t want;
        for (int k = 0; k < 2; k++) begin
            got  = (k == 0) ? dut0 : dut1;
            want = model_out(ms[k], drv[k]);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL cycle inst%0d t=%0t: dut %h, model %h", k, $time, got, want);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits for the start of instance k, answers after lat cycles, holds DONE for stalls extra cycles,
    // then drops the owner's request in the IDLE cycle that follows.
    task automatic run_op(input int k, input int lat, input int stalls, output logic who, output time t_done);
        int              guard;
        out_t            o;
        logic [2*DW-1:0] want;
        guard = 0;
        while (!ms[k].fresh && guard < 40) begin
            tick();
            guard++;
        end
        o = (k == 0) ? dut0 : dut1;
        check($sformatf("start inst%0d", k), o.start, 1'b1);
        who  = ms[k].who;
        want = unit_calc(ms[k].op, ms[k].a, ms[k].b);
        repeat (lat) tick();
        drv[k].ready = 1'b1;
        drv[k].res   = want;
        tick();
        drv[k].ready = 1'b0;
        drv[k].res   = ~want;
        t_done       = $time;
        for (int s = 0; s <= stalls; s++) begin
            o = (k == 0) ? dut0 : dut1;
            check($sformatf("done inst%0d hold %0d", k, s), who ? o.done2 : o.done1, 1'b1);
            check($sformatf("result inst%0d hold %0d", k, s), o.result, want);
            if (s > 0) check($sformatf("no start in DONE inst%0d %0d", k, s), o.start, 1'b0);
            drv[k].stall = (s < stalls);
            tick();
        end
        if (who) drv[k].req2 = 1'b0;
        else     drv[k].req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic who;
        time  t0;
        time  td;
        int   exp_order [4];
        int   exp_lo    [4];
        int   sent1;
        int   sent2;

        exp_order = '{1, 2, 1, 2};
        exp_lo    = '{33, 36, 63, 66};
        drv[0] = '0;
        drv[1] = '0;
        rst    = 1'b1;
        repeat (2) tick();
        check("reset start", dut0.start, 1'b0);
        check("reset annul", dut0.annul, 1'b0);
        check("reset done", {dut0.done1, dut0.done2}, 2'b00);
        check("reset op/a/b", {dut0.op, dut0.a, dut0.b}, 66'd0);
        check("reset result", dut0.result, 64'd0);
        rst = 1'b0;

        // DIV 100/7, ready four cycles after start.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b10; drv[0].a1 = 32'd100; drv[0].b1 = 32'd7;
        tick();
        t0 = $time;
        check("t1 start", dut0.start, 1'b1);
        check("t1 latched op", dut0.op, 2'b10);
        check("t1 latched a", dut0.a, 32'd100);
        check("t1 latched b", dut0.b, 32'd7);
        drv[0].a1 = 32'h5555_5555; drv[0].b1 = 32'd0;
        run_op(0, 4, 0, who, td);
        check("t1 done latency", (td - t0) / 10, 5);
        check("t1 result", dut0.result, {32'd2, 32'd14});
        check("t1 model result", ms[0].result, {32'd2, 32'd14});

        // Simultaneous requests with fixed priority: sub1 first, sub2 right after.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b00; drv[0].a1 = 32'hFFFF_FFFD; drv[0].b1 = 32'd5;
        drv[0].req2 = 1'b1; drv[0].op2 = 2'b01; drv[0].a2 = 32'd7;         drv[0].b2 = 32'd9;
        tick();
        check("t2 sub1 wins", dut0.a, 32'hFFFF_FFFD);
        check("t2 stall2", dut0.stall2, 1'b1);
        run_op(0, 2, 0, who, td);
        check("t2 first owner", who, 1'b0);
        check("t2 signed product", dut0.result, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        check("t2 stall2 in IDLE", dut0.stall2, 1'b1);
        tick();
        check("t2 sub2 start", dut0.start, 1'b1);
        check("t2 sub2 operand", dut0.a, 32'd7);
        run_op(0, 1, 0, who, td);
        check("t2 second owner", who, 1'b1);
        check("t2 unsigned product", dut0.result, 64'd63);

        // Round robin, both sub-units requesting twice back to back.
        drv[1].req1 = 1'b1; drv[1].op1 = 2'b01; drv[1].a1 = 32'd11; drv[1].b1 = 32'd3;
        drv[1].req2 = 1'b1; drv[1].op2 = 2'b01; drv[1].a2 = 32'd12; drv[1].b2 = 32'd3;
        sent1 = 1;
        sent2 = 1;
        for (int n = 0; n < 4; n++) begin
            run_op(1, 1, 0, who, td);
            check($sformatf("t3 grant %0d", n), who + 1, exp_order[n]);
            check($sformatf("t3 result %0d", n), dut1.result, exp_lo[n]);
            if (!who && sent1 < 2) begin drv[1].req1 = 1'b1; drv[1].a1 = 32'd21; sent1++; end
            if (who && sent2 < 2)  begin drv[1].req2 = 1'b1; drv[1].a2 = 32'd22; sent2++; end
        end

        // DONE held by stall_i for three cycles while sub2 waits.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b11; drv[0].a1 = 32'd50; drv[0].b1 = 32'd8;
        drv[0].req2 = 1'b1; drv[0].op2 = 2'b00; drv[0].a2 = 32'd3;  drv[0].b2 = 32'd4;
        run_op(0, 2, 3, who, td);
        check("t4 owner", who, 1'b0);
        check("t4 result", dut0.result, {32'd2, 32'd6});
        run_op(0, 0, 0, who, td);
        check("t4 sub2 result", dut0.result, 64'd12);

        // Flush two cycles after start, with a unit result in the flush cycle.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b00; drv[0].a1 = 32'd6; drv[0].b1 = 32'd7;
        tick();
        check("t5 start", dut0.start, 1'b1);
        repeat (2) tick();
        drv[0].flush = 1'b1; drv[0].ready = 1'b1; drv[0].res = 64'd42; drv[0].req1 = 1'b0;
        tick();
        check("t5 annul", dut0.annul, 1'b1);
        check("t5 no done", {dut0.done1, dut0.done2}, 2'b00);
        check("t5 result kept", dut0.result, 64'd12);
        drv[0].flush = 1'b0; drv[0].ready = 1'b0;
        tick();
        check("t5 annul single", dut0.annul, 1'b0);
        check("t5 idle no start", dut0.start, 1'b0);

        // Reset in the middle of an op, then MULTU 0xFFFFFFFF * 2 from sub2.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b11; drv[0].a1 = 32'd9; drv[0].b1 = 32'd3;
        repeat (2) tick();
        rst = 1'b1; drv[0].req1 = 1'b0;
        tick();
        check("t6 reset result", dut0.result, 64'd0);
        check("t6 reset op/a/b", {dut0.op, dut0.a, dut0.b}, 66'd0);
        check("t6 reset pulses", {dut0.start, dut0.annul, dut0.done1, dut0.done2}, 4'd0);
        rst = 1'b0;
        drv[0].req2 = 1'b1; drv[0].op2 = 2'b01; drv[0].a2 = 32'hFFFF_FFFF; drv[0].b2 = 32'd2;
        run_op(0, 3, 0, who, td);
        check("t6 result", dut0.result, {32'd1, 32'hFFFF_FFFE});

        // Division by zero goes to the unit untouched.
        drv[0].req1 = 1'b1; drv[0].op1 = 2'b10; drv[0].a1 = 32'hFFFF_FFF8; drv[0].b1 = 32'd0;
        tick();
        check("t7 zero divisor", dut0.b, 32'd0);
        run_op(0, 1, 0, who, td);
        check("t7 result", dut0.result, {32'hFFFF_FFF8, 32'hFFFF_FFFF});

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
